step_segment_sequencer: RTL and testbench

Upstream feeder for the step pulse generator in the CNC SoC. Buffers motion segments (step count + direction) pushed by the HPS/Avalon register interface in a small FIFO. Sequences them into the pulse generator one at a time:
- drives direction with a guaranteed setup time before any step;
- issues the one-cycle load write;
- waits for terminal count before fetching the next segment.

---
 rtl/step_segment_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_step_segment_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/step_segment_sequencer.sv
// step_segment_sequencer
//   Buffers motion segments (step count + direction) in a small circular
//   FIFO and feeds them one at a time into the step pulse generator. A
//   direction change holds dir_out stable for dir_setup_cycles before the
//   load strobe. The next segment is not fetched until the pulse generator
//   reports terminal count.
//
// Optional feature: define STEP_SEQ_UNDERRUN_EN to enable the sticky
//   underrun (motion starved) flag. When undefined, underrun is tied 0.
//
// Ports:
//   clock_in          system clock
//   reset             synchronous, active-high reset
//   seg_write         push one segment (seg_count, seg_dir) at rising edge
//   seg_count         segment step count
//   seg_dir           segment direction
//   run               1 = sequence and step, 0 = pause
//   pg_tc             pulse generator terminal count (1 = idle/done)
//   pg_write          one-cycle load strobe to the pulse generator
//   pg_initial_count  count presented with pg_write, held otherwise
//   pg_en             pulse generator enable, registered copy of run
//   dir_out           stepper direction pin
//   fifo_full         FIFO holds 2^depth_log2 entries
//   fifo_empty        FIFO holds no entries
//   fifo_level        number of stored entries
//   busy              sequencer not in IDLE
//   underrun          sticky starvation flag
//   underrun_clr      clears underrun
//
// Push handshake: seg_write acts as valid and !fifo_full as ready; an entry
// is stored only on an edge where both hold. A push while full is dropped
// with no side effects. All outputs are driven from registers.
module step_segment_sequencer #(
    parameter int width            = 4,
    parameter int depth_log2       = 3,
    parameter int dir_setup_cycles = 16
) (
    input  logic                  clock_in,
    input  logic                  reset,
    input  logic                  seg_write,
    input  logic [width-1:0]      seg_count,
    input  logic                  seg_dir,
    input  logic                  run,
    input  logic                  pg_tc,
    output logic                  pg_write,
    output logic [width-1:0]      pg_initial_count,
    output logic                  pg_en,
    output logic                  dir_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [depth_log2:0]   fifo_level,
    output logic                  busy,
    output logic                  underrun,
    input  logic                  underrun_clr
);

    localparam int depth = 1 << depth_log2;
    localparam logic [depth_log2:0]   lvl_one  = (depth_log2+1)'(1);
    localparam logic [depth_log2:0]   lvl_full = (depth_log2+1)'(depth);
    localparam logic [depth_log2-1:0] ptr_one  = depth_log2'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIR_SETUP,
        ST_LOAD,
        ST_ARM,
        ST_RUN
    } state_t;

    state_t state_q, state_d;

    logic [width:0]          mem [depth];
    logic [depth_log2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [depth_log2:0]     level_q, level_d;
    logic                    full_q, empty_q;
    logic [width-1:0]        seg_count_q, pic_q;
    logic                    dir_q;
    logic [7:0]              setup_q, setup_d;
    logic                    pg_write_q, pg_en_q, busy_q;
    logic                    push, pop, latch;
    logic [width-1:0]        head_count;
    logic                    head_dir;

    assign head_count = mem[rd_ptr_q][width-1:0];
    assign head_dir   = mem[rd_ptr_q][width];

    assign push = seg_write && !full_q;
    // Pops happen only from IDLE; zero-count entries are popped and discarded.
    assign pop  = (state_q == ST_IDLE) && run && !empty_q;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + lvl_one;
            2'b01:   level_d = level_q - lvl_one;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        setup_d = setup_q;
        latch   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop && (head_count != '0)) begin
                    latch = 1'b1;
                    if (head_dir != dir_q) begin
                        state_d = ST_DIR_SETUP;
                        setup_d = 8'(dir_setup_cycles);
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DIR_SETUP: begin
                // Pausing freezes the setup countdown.
                if (run) begin
                    if (setup_q <= 8'd1) state_d = ST_LOAD;
                    else                 setup_d = setup_q - 8'd1;
                end
            end
            ST_LOAD: state_d = ST_ARM;
            ST_ARM:  if (!pg_tc) state_d = ST_RUN;
            ST_RUN:  if (pg_tc)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Storage needs no reset: emptiness is tracked by the pointers/level.
    always_ff @(posedge clock_in) begin
        if (push) mem[wr_ptr_q] <= {seg_dir, seg_count};
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            seg_count_q <= '0;
            dir_q       <= 1'b0;
            setup_q     <= '0;
            pg_write_q  <= 1'b0;
            pic_q       <= '0;
            pg_en_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + ptr_one;
            if (pop)  rd_ptr_q <= rd_ptr_q + ptr_one;
            level_q <= level_d;
            full_q  <= (level_d == lvl_full);
            empty_q <= (level_d == '0);
            if (latch) begin
                seg_count_q <= head_count;
                dir_q       <= head_dir;
            end
            setup_q    <= setup_d;
            pg_write_q <= (state_d == ST_LOAD);
            // The count goes out only with the strobe; when LOAD follows IDLE
            // directly the latched copy is not yet available, so use the head.
            if (state_d == ST_LOAD)
                pic_q <= (state_q == ST_IDLE) ? head_count : seg_count_q;
            pg_en_q <= run;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

`ifdef STEP_SEQ_UNDERRUN_EN
    logic underrun_q;
    always_ff @(posedge clock_in) begin
        if (reset)
            underrun_q <= 1'b0;
        else if ((state_q == ST_RUN) && (state_d == ST_IDLE) && run && empty_q)
            underrun_q <= 1'b1;   // set has priority over clear
        else if (underrun_clr)
            underrun_q <= 1'b0;
    end
    assign underrun = underrun_q;
`else
    logic unused_underrun_clr;
    assign unused_underrun_clr = underrun_clr;
    assign underrun = 1'b0;
`endif

    assign pg_write         = pg_write_q;
    assign pg_initial_count = pic_q;
    assign pg_en            = pg_en_q;
    assign dir_out          = dir_q;
    assign fifo_full        = full_q;
    assign fifo_empty       = empty_q;
    assign fifo_level       = level_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_step_segment_sequencer.sv
// Bench for step_segment_sequencer: directed scenarios plus randomized
// segment streams, a pulse generator model driving pg_tc, and a scoreboard
// of expected loads in push order.
module tb_step_segment_sequencer;

    localparam int W     = 4;
    localparam int DL2   = 3;
    localparam int DSC   = 16;
    localparam int DEPTH = 1 << DL2;
`ifdef STEP_SEQ_UNDERRUN_EN
    localparam bit UR_EN = 1'b1;
`else
    localparam bit UR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clock_in = 1'b0;
    logic reset = 1'b1;
    always #10 clock_in = ~clock_in;

    logic           seg_write = 1'b0;
    logic [W-1:0]   seg_count = '0;
    logic           seg_dir = 1'b0;
    logic           run = 1'b0;
    logic           pg_tc = 1'b1;
    logic           underrun_clr = 1'b0;
    logic           pg_write;
    logic [W-1:0]   pg_initial_count;
    logic           pg_en;
    logic           dir_out;
    logic           fifo_full;
    logic           fifo_empty;
    logic [DL2:0]   fifo_level;
    logic           busy;
    logic           underrun;

    step_segment_sequencer #(
        .width(W), .depth_log2(DL2), .dir_setup_cycles(DSC)
    ) dut (
        .clock_in(clock_in), .reset(reset),
        .seg_write(seg_write), .seg_count(seg_count), .seg_dir(seg_dir),
        .run(run), .pg_tc(pg_tc),
        .pg_write(pg_write), .pg_initial_count(pg_initial_count),
        .pg_en(pg_en), .dir_out(dir_out),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
        .busy(busy), .underrun(underrun), .underrun_clr(underrun_clr)
    );

    // ---------------- scoreboard state ----------------
    int           n_vec = 0;
    int           n_err = 0;
    logic [W:0]   exp_q[$];          // {dir, count} of segments that must load
    int           model_level = 0;
    logic         exp_dir = 1'b0;     // dir of last non-zero segment accepted
    logic [W-1:0] exp_pic = '0;
    logic         exp_pg_en = 1'b0;
    logic         was_reset = 1'b1;
    logic         prev_write = 1'b0;
    int           pg_rem = 0;
    logic         pg_skip = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clock_in) begin
        was_reset = reset;
        exp_pg_en = reset ? 1'b0 : run;
    end

    // Load monitor and pulse generator model, evaluated mid-cycle.
    always @(negedge clock_in) begin
        logic [W:0] e;
        if (was_reset) exp_pic = '0;
        if (pg_write) begin
            check_val("pg_write_width", 32'(prev_write), 32'd0);
            check_val("load_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                exp_pic = e[W-1:0];
                check_val("load_count", 32'(pg_initial_count), 32'(e[W-1:0]));
                check_val("load_dir", 32'(dir_out), 32'(e[W]));
            end
        end else begin
            check_val("pic_hold", 32'(pg_initial_count), 32'(exp_pic));
        end
        check_val("pg_en", 32'(pg_en), 32'(exp_pg_en));
        prev_write = pg_write;
        // Pulse generator: accepts a load, waits one cycle, then counts
        // down while enabled and raises terminal count at zero.
        if (was_reset) begin
            pg_tc = 1'b1; pg_rem = 0; pg_skip = 1'b0;
        end else if (pg_write) begin
            pg_rem = int'(pg_initial_count); pg_tc = 1'b0; pg_skip = 1'b1;
        end else if (pg_skip) begin
            pg_skip = 1'b0;
        end else if (pg_en && pg_rem > 0) begin
            pg_rem--;
            if (pg_rem == 0) pg_tc = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_seg(input logic [W-1:0] c, input logic d);
        seg_count = c; seg_dir = d; seg_write = 1'b1;
        @(negedge clock_in);
        seg_write = 1'b0;
        if (model_level < DEPTH) begin
            model_level++;
            if (c != '0) begin
                exp_q.push_back({d, c});
                exp_dir = d;
            end
        end
        check_val("fifo_level", 32'(fifo_level), 32'(model_level));
        check_val("fifo_full", 32'(fifo_full), 32'(model_level == DEPTH));
        check_val("fifo_empty", 32'(fifo_empty), 32'(model_level == 0));
    endtask

    // Raise run at a negedge and count cycles until the load strobe.
    task automatic start_run(output int lat);
        run = 1'b1;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock_in);
            lat++;
            if (pg_write) break;
        end
    endtask

    task automatic drain(input int budget, input bit pauses);
        for (int i = 0; i < budget; i++) begin
            if (pauses) run = ($urandom_range(0, 5) != 0);
            else        run = 1'b1;
            @(negedge clock_in);
            if (!busy && fifo_empty) break;
        end
        check_val("drain_done", 32'({busy, fifo_empty}), 32'd1);
        check_val("loads_pending", 32'(exp_q.size()), 32'd0);
        check_val("dir_after_drain", 32'(dir_out), 32'(exp_dir));
        model_level = 0;
        check_val("level_after_drain", 32'(fifo_level), 32'd0);
    endtask

    task automatic check_reset_vals();
        check_val("rst_pg_write", 32'(pg_write), 32'd0);
        check_val("rst_pic", 32'(pg_initial_count), 32'd0);
        check_val("rst_pg_en", 32'(pg_en), 32'd0);
        check_val("rst_dir_out", 32'(dir_out), 32'd0);
        check_val("rst_fifo_empty", 32'(fifo_empty), 32'd1);
        check_val("rst_fifo_full", 32'(fifo_full), 32'd0);
        check_val("rst_fifo_level", 32'(fifo_level), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_underrun", 32'(underrun), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        int n;
        reset = 1'b1;
        repeat (2) @(negedge clock_in);
        check_reset_vals();
        reset = 1'b0;

        // Reset with entries buffered.
        push_seg(4'd1, 1'b1);
        push_seg(4'd2, 1'b0);
        push_seg(4'd3, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clock_in);
        check_reset_vals();
        reset = 1'b0;
        exp_q.delete();
        model_level = 0;
        exp_dir = 1'b0;

        // Single segment, same direction.
        push_seg(4'd5, 1'b0);
        start_run(lat);
        check_val("lat_same_dir", 32'(lat), 32'd1);
        drain(500, 1'b0);
        check_val("underrun_set", 32'(underrun), 32'(UR_EN));
        run = 1'b0;
        underrun_clr = 1'b1;
        @(negedge clock_in);
        underrun_clr = 1'b0;
        check_val("underrun_clr", 32'(underrun), 32'd0);

        // Direction change, then same direction.
        push_seg(4'd3, 1'b1);
        start_run(lat);
        check_val("lat_dir_change", 32'(lat), 32'(DSC + 1));
        drain(500, 1'b0);
        run = 1'b0;
        push_seg(4'd2, 1'b1);
        start_run(lat);
        check_val("lat_same_dir2", 32'(lat), 32'd1);
        drain(500, 1'b0);
        run = 1'b0;

        // FIFO boundary: 9th push dropped.
        for (int i = 0; i < DEPTH + 1; i++) push_seg(W'(i + 1), 1'b0);
        drain(1500, 1'b0);
        run = 1'b0;

        // Zero count discarded, then pause mid-RUN.
        push_seg(4'd0, 1'b0);
        push_seg(4'd4, 1'b0);
        start_run(lat);
        check_val("lat_after_zero", 32'(lat), 32'd2);
        repeat (2) @(negedge clock_in);
        run = 1'b0;
        @(negedge clock_in);
        check_val("pause_pg_en", 32'(pg_en), 32'd0);
        check_val("pause_busy", 32'(busy), 32'd1);
        repeat (5) @(negedge clock_in);
        check_val("pause_hold_busy", 32'(busy), 32'd1);
        check_val("pause_hold_tc", 32'(pg_tc), 32'd0);
        drain(500, 1'b0);
        run = 1'b0;

        // Randomized segment streams with random pauses.
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 11);
            for (int k = 0; k < n; k++)
                push_seg(W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            drain(3000, 1'b1);
            run = 1'b0;
            @(negedge clock_in);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
